// File: rtl/k_wptr_wfull.sv
// Write-side pointer, address and full/almost-full/level/overflow flags
// for a dual-clock gray-pointer FIFO; lives entirely in the wclk domain.
//
// Ports:
//   wclk      write clock, rising edge
//   wrst      asynchronous active-high reset
//   winc      write request this cycle
//   wq2_rptr  gray read pointer, already synchronized into wclk
//   wptr      registered gray write pointer (to read-side synchronizer)
//   waddr     memory write address (low bits of binary pointer)
//   wfull     registered full flag
//   wafull    registered almost-full flag
//   wlevel    registered occupancy seen from the write side
//   wover     sticky overflow (write attempted while full)
module k_wptr_wfull #(
  parameter int addr_size    = 4,
  parameter int afull_thresh = 2
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [addr_size:0]   wq2_rptr,
  output logic [addr_size:0]   wptr,
  output logic [addr_size-1:0] waddr,
  output logic                 wfull,
  output logic                 wafull,
  output logic [addr_size:0]   wlevel,
  output logic                 wover
);

  localparam int unsigned AF_LIM =
    (2 ** addr_size) - afull_thresh;

  logic [addr_size:0] wbin;
  logic [addr_size:0] wbinnext;
  logic [addr_size:0] wgraynext;
  logic [addr_size:0] rbin;
  logic [addr_size:0] wdiff;
  logic [addr_size:0] full_ptr;
  logic               wen;

  assign wen       = winc & ~wfull;
  assign wbinnext  = wbin + {{addr_size{1'b0}}, wen};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;
  assign waddr     = wbin[addr_size-1:0];

  // Bit i of the binary value is the XOR of all gray bits from i up.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= addr_size; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // The write pointer is exactly one lap ahead of the read pointer when
  // the top two gray bits differ and the rest match.
  assign full_ptr = {~wq2_rptr[addr_size:addr_size-1],
                     wq2_rptr[addr_size-2:0]};

  assign wdiff = wbinnext - rbin;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wafull <= 1'b0;
      wlevel <= '0;
      wover  <= 1'b0;
    end else begin
      wbin   <= wbinnext;
      wptr   <= wgraynext;
      wfull  <= (wgraynext == full_ptr);
      wafull <= (wdiff >= AF_LIM[addr_size:0]);
      wlevel <= wdiff;
      wover  <= wover | (winc & wfull);
    end
  end

endmodule

// File: tb/tb_k_wptr_wfull.sv
// Scoreboard bench for k_wptr_wfull: a count-based FIFO model predicts
// every post-edge output; a separate monitor pops and compares.
module tb_k_wptr_wfull;

  localparam int AS = 4;
  localparam int AT = 2;
  localparam int D  = 16;

  logic          wclk = 1'b0;
  logic          wrst;
  logic          winc;
  logic [AS:0]   wq2_rptr;
  logic [AS:0]   wptr;
  logic [AS-1:0] waddr;
  logic          wfull;
  logic          wafull;
  logic [AS:0]   wlevel;
  logic          wover;

  k_wptr_wfull #(
    .addr_size   (AS),
    .afull_thresh(AT)
  ) dut (
    .wclk    (wclk),
    .wrst    (wrst),
    .winc    (winc),
    .wq2_rptr(wq2_rptr),
    .wptr    (wptr),
    .waddr   (waddr),
    .wfull   (wfull),
    .wafull  (wafull),
    .wlevel  (wlevel),
    .wover   (wover)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int ptr;
    int addr;
    int full;
    int afull;
    int level;
    int over;
    int moved;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: total writes accepted and total reads seen.
  int wcount, rcount, wc_d1, wc_d2;
  bit m_full, m_over;

  function automatic int gray(int n);
    int b;
    b = n % (2 * D);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_wptr"},   int'(wptr),   0);
    chk({tag, "_waddr"},  int'(waddr),  0);
    chk({tag, "_wfull"},  int'(wfull),  0);
    chk({tag, "_wafull"}, int'(wafull), 0);
    chk({tag, "_wlevel"}, int'(wlevel), 0);
    chk({tag, "_wover"},  int'(wover),  0);
  endtask

  task automatic model_reset();
    wcount = 0;
    rcount = 0;
    wc_d1  = 0;
    wc_d2  = 0;
    m_full = 0;
    m_over = 0;
  endtask

  // Drive one cycle of stimulus and queue the expected post-edge state.
  task automatic step(bit inc, int rnew);
    exp_t e;
    int   acc, lvl;
    @(negedge wclk);
    winc     = inc;
    rcount   = rnew;
    wq2_rptr = gray(rnew);
    acc      = (inc && !m_full) ? 1 : 0;
    m_over   = m_over | (inc && m_full);
    wcount   = wcount + acc;
    lvl      = wcount - rcount;
    m_full   = (lvl == D);
    e.ptr    = gray(wcount);
    e.addr   = wcount % D;
    e.full   = int'(m_full);
    e.afull  = (lvl >= D - AT) ? 1 : 0;
    e.level  = lvl;
    e.over   = int'(m_over);
    e.moved  = acc;
    q.push_back(e);
    wc_d2 = wc_d1;
    wc_d1 = wcount;
  endtask

  task automatic reset_pulse();
    @(negedge wclk);
    #1;
    winc = 1'b1;
    wrst = 1'b1;
    #1;
    chk_zero("midrst");
    wq2_rptr = '0;
    model_reset();
    #1;
    wrst = 1'b0;
    winc = 1'b0;
  endtask

  // Monitor: pops one expectation per edge, compares outputs, and checks
  // that the gray pointer moves by exactly one bit per accepted write.
  initial begin
    logic [AS:0] prev;
    exp_t        e;
    forever begin
      @(negedge wclk);
      #4;
      prev = wptr;
      @(posedge wclk);
      #1;
      if (!wrst && q.size() > 0) begin
        e = q.pop_front();
        chk("wptr",   int'(wptr),   e.ptr);
        chk("waddr",  int'(waddr),  e.addr);
        chk("wfull",  int'(wfull),  e.full);
        chk("wafull", int'(wafull), e.afull);
        chk("wlevel", int'(wlevel), e.level);
        chk("wover",  int'(wover),  e.over);
        chk("gray_step", $countones(prev ^ wptr), e.moved);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rnew;
    bit inc;
    model_reset();
    wrst     = 1'b1;
    winc     = 1'b0;
    wq2_rptr = '0;
    #1;
    chk_zero("rst");
    repeat (4) begin
      @(negedge wclk);
      winc = ~winc;
    end
    #1;
    chk_zero("rst_hold");
    @(negedge wclk);
    wrst = 1'b0;
    winc = 1'b0;
    repeat (3) step(0, 0);

    // fill from empty, then overflow attempts
    repeat (16) step(1, 0);
    repeat (3) step(1, 0);
    repeat (2) step(0, 0);

    // drain response from full
    step(0, 1);
    step(0, 3);
    step(0, wc_d2);
    step(0, wc_d2);

    // wrap-around with the read pointer two cycles behind
    repeat (40) step(1, wc_d2);
    repeat (3) step(0, wc_d2);

    // randomized traffic with a lagging reader
    repeat (400) begin
      inc  = ($urandom % 4) != 0;
      rnew = rcount;
      if (rcount < wc_d2 && ($urandom % 3) == 0)
        rnew = rcount + $urandom_range(1, wc_d2 - rcount);
      step(inc, rnew);
    end

    // async reset in the middle of a fill
    reset_pulse();
    repeat (7) step(1, 0);
    reset_pulse();
    repeat (3) step(1, 0);
    step(0, 0);

    @(negedge wclk);
    @(negedge wclk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
